// File: rtl/regdst_wb_tracker.sv
`default_nettype none
// ============================================================================
// Module   : regdst_wb_tracker
// Brief    : RegDst destination select with an in-order pending-writeback
//            queue, valid/ready drain to the register file, and RAW hazard flags.
// Revision : 1.0
// ============================================================================
module regdst_wb_tracker #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4,
    parameter int SP_REG = 29,
    parameter int RA_REG = 31
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [1:0]                 RegDstControl,
    input  logic [31:0]                instr,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [ADDR_W-1:0]          wb_dst,
    input  logic [ADDR_W-1:0]          query_rs,
    input  logic [ADDR_W-1:0]          query_rt,
    output logic                       hazard_rs,
    output logic                       hazard_rt,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [ADDR_W-1:0] w_dst_sel;
    logic              w_enq;
    logic              w_deq;
    logic [DEPTH-1:0]  w_match_rs;
    logic [DEPTH-1:0]  w_match_rt;

    always_comb begin
        w_dst_sel = '0;
        case (RegDstControl)
            2'b00:   w_dst_sel = ADDR_W'(SP_REG);
            2'b01:   w_dst_sel = ADDR_W'(instr[20:16]);
            2'b10:   w_dst_sel = ADDR_W'(RA_REG);
            default: w_dst_sel = ADDR_W'(instr[15:11]);
        endcase
    end

    assign issue_ready = (r_count < C_DEPTH);
    assign wb_valid    = (r_count != '0);
    assign wb_dst      = wb_valid ? r_mem[r_head] : '0;
    assign count       = r_count;

    // Flush wins over both handshakes in the same cycle.
    assign w_enq = issue_valid && issue_ready && !flush;
    assign w_deq = wb_valid && wb_ready && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + PTR_W'(1);
            if (w_deq) r_head <= r_head + PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only entries inside [head, head+count) are ever observed.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= w_dst_sel;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] w_off;
            logic             w_live;
            assign w_off  = PTR_W'(gi) - r_head;
            assign w_live = ({1'b0, w_off} < r_count);
            assign w_match_rs[gi] = w_live && (r_mem[gi] == query_rs) && (r_mem[gi] != '0);
            assign w_match_rt[gi] = w_live && (r_mem[gi] == query_rt) && (r_mem[gi] != '0);
        end
    endgenerate

    assign hazard_rs = |w_match_rs;
    assign hazard_rt = |w_match_rt;

endmodule
`default_nettype wire

// File: tb/tb_regdst_wb_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_regdst_wb_tracker
// Brief    : Directed self-checking bench for regdst_wb_tracker (DEPTH 4).
// Revision : 1.0
// ============================================================================
module tb_regdst_wb_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  RegDstControl;
    logic [31:0] instr;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dst;
    logic [4:0]  query_rs;
    logic [4:0]  query_rt;
    logic        hazard_rs;
    logic        hazard_rt;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    regdst_wb_tracker #(.ADDR_W(5), .DEPTH(4), .SP_REG(29), .RA_REG(31)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .RegDstControl(RegDstControl), .instr(instr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst),
        .query_rs(query_rs), .query_rt(query_rt),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int rt, input int rd);
        return (32'(rt) << 16) | (32'(rd) << 11);
    endfunction

    initial begin
        reset_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; wb_ready = 1'b0;
        RegDstControl = 2'b00; instr = '0; query_rs = '0; query_rt = '0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_dst", wb_dst, 0);
        chk("rst_issue_ready", issue_ready, 1);
        for (int q = 0; q < 32; q += 7) begin
            query_rs = 5'(q); query_rt = 5'(31 - q); #1;
            chk("rst_hazard_rs", hazard_rs, 0);
            chk("rst_hazard_rt", hazard_rt, 0);
        end
        @(negedge clk); reset_n = 1'b1;
        step();
        chk("idle_count", count, 0);

        // Four issues covering each RegDstControl value, no drain.
        instr = mk(8, 12); issue_valid = 1'b1;
        RegDstControl = 2'b00; step();
        chk("enq1_count", count, 1);
        chk("enq1_dst", wb_dst, 29);
        RegDstControl = 2'b01; step();
        RegDstControl = 2'b10; step();
        RegDstControl = 2'b11; step();
        issue_valid = 1'b0;
        chk("full_count", count, 4);
        chk("full_ready", issue_ready, 0);
        wb_ready = 1'b1; #1;
        chk("drain0", wb_dst, 29);
        step(); chk("drain1", wb_dst, 8);
        step(); chk("drain2", wb_dst, 31);
        step(); chk("drain3", wb_dst, 12);
        step();
        chk("drained_count", count, 0);
        chk("drained_valid", wb_valid, 0);
        chk("drained_dst", wb_dst, 0);
        wb_ready = 1'b0;

        // Hazard detection and the zero destination.
        issue_valid = 1'b1; RegDstControl = 2'b01; instr = mk(8, 3); step();
        issue_valid = 1'b0;
        query_rs = 5'd8; query_rt = 5'd0; #1;
        chk("haz_rs_8", hazard_rs, 1);
        chk("haz_rt_0", hazard_rt, 0);
        query_rt = 5'd3; #1;
        chk("haz_rt_3", hazard_rt, 0);
        issue_valid = 1'b1; RegDstControl = 2'b11; instr = mk(8, 0); step();
        issue_valid = 1'b0;
        query_rt = 5'd0; #1;
        chk("zero_count", count, 2);
        chk("zero_haz_rt", hazard_rt, 0);
        wb_ready = 1'b1; #1;
        chk("deq_cycle_haz", hazard_rs, 1);
        step();
        chk("zero_head_dst", wb_dst, 0);
        chk("zero_head_valid", wb_valid, 1);
        chk("after_deq_haz", hazard_rs, 0);
        step();
        chk("zero_drained", count, 0);
        wb_ready = 1'b0;

        // Full queue: simultaneous issue and drain only drains.
        issue_valid = 1'b1; RegDstControl = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            instr = mk(0, k); step();
        end
        query_rs = 5'd5; query_rt = 5'd3; #1;
        chk("full4_count", count, 4);
        chk("full4_haz_rt", hazard_rt, 1);
        chk("full4_haz_rs", hazard_rs, 0);
        instr = mk(0, 5); wb_ready = 1'b1; step();
        chk("full_both_count", count, 3);
        chk("full_both_dst", wb_dst, 2);
        chk("full_both_ready", issue_ready, 1);
        chk("full_both_haz_rs", hazard_rs, 0);
        issue_valid = 1'b0; step();
        chk("half_count", count, 2);
        chk("half_dst", wb_dst, 3);

        // Half-full queue: enqueue+dequeue across the pointer wrap.
        issue_valid = 1'b1;
        instr = mk(0, 5); step();
        chk("wrap1_count", count, 2); chk("wrap1_dst", wb_dst, 4);
        instr = mk(0, 6); step();
        chk("wrap2_count", count, 2); chk("wrap2_dst", wb_dst, 5);
        instr = mk(0, 7); step();
        chk("wrap3_count", count, 2); chk("wrap3_dst", wb_dst, 6);

        // Flush beats both handshakes.
        wb_ready = 1'b0; instr = mk(0, 9); step();
        chk("pre_flush_count", count, 3);
        query_rs = 5'd9; query_rt = 5'd6; #1;
        chk("pre_flush_haz", hazard_rs, 1);
        flush = 1'b1; wb_ready = 1'b1; instr = mk(0, 10); step();
        flush = 1'b0; wb_ready = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", wb_valid, 0);
        chk("flush_haz_rs", hazard_rs, 0);
        chk("flush_haz_rt", hazard_rt, 0);
        instr = mk(0, 10); step();
        chk("post_flush_dst", wb_dst, 10);
        chk("post_flush_count", count, 1);
        instr = mk(0, 11); step();
        issue_valid = 1'b0;
        chk("pre_rst_count", count, 2);

        // Asynchronous reset between edges.
        query_rs = 5'd10; #2;
        reset_n = 1'b0; #1;
        chk("arst_count", count, 0);
        chk("arst_valid", wb_valid, 0);
        chk("arst_dst", wb_dst, 0);
        chk("arst_haz", hazard_rs, 0);
        chk("arst_ready", issue_ready, 1);
        @(negedge clk); reset_n = 1'b1;
        issue_valid = 1'b1; RegDstControl = 2'b10; step();
        issue_valid = 1'b0;
        chk("post_rst_dst", wb_dst, 31);
        chk("post_rst_count", count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regdst_wb_tracker.md
# regdst_wb_tracker

Parametrised successor to the combinational RegDst mux of the multicycle MIPS datapath. It selects the register-file write destination ($sp, rt, $ra or rd) for each issued instruction. It also holds the selected destinations in an in-order queue of pending writebacks, drains them through a valid/ready handshake to the register-file write port, and flags read-after-write hazards for the rs/rt operands of the instruction being decoded. It sits between the control unit/instruction register and the register bank.

## Interface
- ADDR_W, 5, register address width; must be >= 5
- DEPTH, 4, pending-writeback entries; power of two, >= 2
- SP_REG, 29, destination for RegDstControl 2'b00
- RA_REG, 31, destination for RegDstControl 2'b10

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all pending entries
- issue_valid  in  1  decode presents an instruction that will write a register
- issue_ready  out  1  tracker accepts the issue this cycle
- RegDstControl  in  2  00 SP_REG, 01 rt, 10 RA_REG, 11 rd
- instr  in  32  instruction word; rt = instr[20:16], rd = instr[15:11]
- wb_valid  out  1  head entry available for writeback
- wb_ready  in  1  register bank consumes the head entry
- wb_dst  out  ADDR_W  destination of head entry
- query_rs, query_rt  in  ADDR_W  operand addresses of the decoding instruction
- hazard_rs, hazard_rt  out  1  operand matches a pending nonzero destination
- count  out  clog2(DEPTH)+1  number of pending entries

## Operation
- Destination select is combinational from RegDstControl and instr. rt/rd are zero-extended to ADDR_W. SP_REG and RA_REG are truncated to ADDR_W.
- Enqueue fires when issue_valid && issue_ready. The selected destination is written at the tail and the tail pointer increments modulo DEPTH.
- Dequeue fires when wb_valid && wb_ready. The head pointer increments modulo DEPTH.
- issue_ready = (count < DEPTH). When the queue is full, ready stays low even if a dequeue fires that cycle; there is no full-bypass.
- wb_valid = (count != 0). wb_dst = head entry, or 0 when empty.
- Simultaneous enqueue and dequeue when 0 < count < DEPTH: both fire and count is unchanged.
- Enqueue into an empty queue with wb_ready high: the new entry is not dequeued in the same cycle (no empty-bypass).
- Destination 0 is enqueued to preserve ordering. It is presented on wb_dst but never raises a hazard.
- hazard_x = OR over valid entries of (entry == query_x && entry != 0). This is combinational on the current registered state, so an entry being dequeued this cycle still raises a hazard this cycle.
- flush: count, head and tail return to 0. Flush has priority over enqueue and dequeue in the same cycle; neither takes effect.
- issue_valid low or issue_ready low: no state change from the issue side. RegDstControl and instr are don't-care.

## Timing
- Reset (reset_n low, asynchronous): count 0, head 0, tail 0, wb_valid 0, wb_dst 0, hazard_rs/rt 0, issue_ready 1. Entry storage contents are don't-care.
- Enqueue-to-visibility latency is 1 cycle. An entry accepted at edge N appears on wb_dst/wb_valid, hazards and count after edge N.
- Dequeue takes effect at the edge where the handshake is sampled. The next head appears after that edge.
- reset_n asserted mid-operation discards all pending entries immediately. Outputs take reset values without waiting for a clock edge.
- Pointer wrap: after DEPTH enqueues the tail returns to 0. Ordering is preserved across the wrap.

## Test plan
- Reset then idle: wb_valid 0, wb_dst 0, count 0, issue_ready 1, hazards 0 for all query values.
- Issue four instructions, RegDstControl 00/01/10/11, instr rt=8, rd=12, with wb_ready 0: count 4, issue_ready 0. With wb_ready 1, drain in order 29, 8, 31, 12.
- Queue holds {8}, query_rs=8, query_rt=0: hazard_rs 1, hazard_rt 0. Enqueue rd=0, query_rt=0: hazard_rt stays 0.
- Full queue (DEPTH 4), issue_valid and wb_ready both high: one dequeue only, count 3, next cycle issue_ready 1. Half-full queue, both high: count unchanged, order kept across the pointer wrap.
- Queue holds 3 entries, flush, issue_valid and wb_ready all high in one cycle: next cycle count 0, wb_valid 0, hazards 0.
- reset_n pulsed low between edges with 2 entries pending: wb_valid and count drop to 0 before the next edge.
